// File: rtl/fb_pkg.sv
// fb_pkg: geometry, index widths and scanner state encoding shared by the
// framebuffer port arbiter and its address calculator.
package fb_pkg;

    localparam int COLS = 79;
    localparam int ROWS = 16;
    localparam int XW   = 7;
    localparam int YW   = 4;
    localparam int AW   = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: combinational (x,y) -> linear framebuffer address,
// addr = y*COLS + x, truncated to the address width.
module fb_addr_calc #(
    parameter int COLS = fb_pkg::COLS
) (
    input  logic [fb_pkg::XW-1:0] i_x,
    input  logic [fb_pkg::YW-1:0] i_y,
    output logic [fb_pkg::AW-1:0] o_addr
);
    import fb_pkg::*;

    assign o_addr = AW'(int'(i_y) * COLS + int'(i_x));

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer between a row-major
// display scanner and a pixel write port, with round-robin arbitration on
// conflicts. Scanner issues one read, waits a cycle for data, then holds the
// pixel until the display accepts it.
//
// Optional build macro FB_ARB_RANGE_CHK_EN: out-of-range writes are acked
// but suppressed (mem_we=0) and raise the sticky wr_err flag. Without it,
// every granted write goes to the computed address and wr_err is 0.
//
// state | meaning
// IDLE  | no scan; waits for frame_start
// ISSUE | scanner requests the port; read address is the scan counters
// WAIT  | read in flight; mem_rdata captured at the end of this cycle
// HOLD  | pixel presented on scan_data until scan_ready
module fb_port_arbiter #(
    parameter int COLS = fb_pkg::COLS,
    parameter int ROWS = fb_pkg::ROWS,
    parameter int DW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  scan_busy,
    output logic                  frame_done,
    output logic                  scan_valid,
    output logic [DW-1:0]         scan_data,
    input  logic                  scan_ready,
    input  logic                  wr_req,
    input  logic [fb_pkg::XW-1:0] wr_x,
    input  logic [fb_pkg::YW-1:0] wr_y,
    input  logic [DW-1:0]         wr_data,
    output logic                  wr_ack,
    output logic [fb_pkg::AW-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  wr_err
);
    import fb_pkg::*;

    // Round-robin bit records who was granted last.
    localparam logic RR_SCAN = 1'b0;
    localparam logic RR_WR   = 1'b1;

    scan_state_t   r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_last;
    logic          r_rr;
    logic [DW-1:0] r_scan_data;

    logic          w_scan_req;
    logic          w_wr_grant;
    logic          w_scan_grant;
    logic          w_accept;
    logic          w_x_end;
    logic          w_y_end;
    logic [XW-1:0] w_addr_x;
    logic [YW-1:0] w_addr_y;

    // Writer wins when alone or when the scanner was granted last; reset
    // blocks the writer so all outputs stay low during reset.
    assign w_scan_req   = (r_state == ST_ISSUE);
    assign w_wr_grant   = wr_req & ~rst & (~w_scan_req | (r_rr == RR_SCAN));
    assign w_scan_grant = w_scan_req & ~w_wr_grant;
    assign w_accept     = (r_state == ST_HOLD) & scan_ready;
    assign w_x_end      = (r_x == XW'(COLS - 1));
    assign w_y_end      = (r_y == YW'(ROWS - 1));

    assign w_addr_x = w_wr_grant ? wr_x : r_x;
    assign w_addr_y = w_wr_grant ? wr_y : r_y;

    fb_addr_calc #(
        .COLS (COLS)
    ) u_addr_calc (
        .i_x    (w_addr_x),
        .i_y    (w_addr_y),
        .o_addr (mem_addr)
    );

    assign scan_busy  = (r_state != ST_IDLE);
    assign scan_valid = (r_state == ST_HOLD);
    assign scan_data  = r_scan_data;
    assign frame_done = w_accept & r_last;
    assign wr_ack     = w_wr_grant;
    assign mem_wdata  = wr_data;

    // Round-robin bit follows every grant, whoever receives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= RR_SCAN;
        end else if (w_wr_grant) begin
            r_rr <= RR_WR;
        end else if (w_scan_grant) begin
            r_rr <= RR_SCAN;
        end
    end

    // Scanner FSM with its row-major counters and captured pixel.
    // Counters advance on the grant, so r_last remembers whether the pixel
    // in flight is the final one of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_last      <= 1'b0;
            r_scan_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state <= ST_ISSUE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (w_scan_grant) begin
                        r_state <= ST_WAIT;
                        r_last  <= w_x_end & w_y_end;
                        if (w_x_end) begin
                            r_x <= '0;
                            r_y <= w_y_end ? '0 : r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_scan_data <= mem_rdata;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (scan_ready) begin
                        r_state <= r_last ? ST_IDLE : ST_ISSUE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FB_ARB_RANGE_CHK_EN
    logic w_in_range;
    logic r_wr_err;

    assign w_in_range = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);
    assign mem_we     = w_wr_grant & w_in_range;
    assign wr_err     = r_wr_err;

    // Sticky flag: any acked out-of-range write sets it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else if (w_wr_grant & ~w_in_range) begin
            r_wr_err <= 1'b1;
        end
    end
`else
    assign mem_we = w_wr_grant;
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed bench for fb_port_arbiter with a one-cycle
// read-latency framebuffer model.
module tb_fb_port_arbiter;
    localparam int COLS = 79;
    localparam int ROWS = 16;
    localparam int DW   = 8;
    localparam int NPIX = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          scan_busy;
    logic          frame_done;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          scan_ready;
    logic          wr_req;
    logic [6:0]    wr_x;
    logic [3:0]    wr_y;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [10:0]   mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          wr_err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem     [0:2047];
    bit            wvalid  [0:2047];
    logic [DW-1:0] exp_mem [0:2047];

    fb_port_arbiter #(.COLS(COLS), .ROWS(ROWS), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .scan_busy   (scan_busy),
        .frame_done  (frame_done),
        .scan_valid  (scan_valid),
        .scan_data   (scan_data),
        .scan_ready  (scan_ready),
        .wr_req      (wr_req),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ (i >> 4) ^ 8'h5A);
    endfunction

    // Framebuffer model: unwritten locations return the fill pattern.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]    <= mem_wdata;
            wvalid[mem_addr] <= 1'b1;
        end
        mem_rdata <= wvalid[mem_addr] ? mem[mem_addr] : pat(int'(mem_addr));
    end

    // Advance to 2 time units after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; wr_req = 1'b0; frame_start = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; scan_ready = 1'b1;
        wr_req = 1'b1; wr_x = 7'd5; wr_y = 4'd2; wr_data = 8'h00;
        cyc(); #1;
        checks++; if (scan_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b want=0", scan_busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b want=0", frame_done); end
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b want=0", scan_valid); end
        checks++; if (scan_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h want=0", scan_data); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b want=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b want=0", mem_we); end
        checks++; if (mem_addr !== 11'd0) begin failures++; $display("FAIL rst_addr got=%0d want=0", mem_addr); end
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b want=0", wr_err); end
        cyc();
        rst = 1'b0; wr_req = 1'b0; scan_ready = 1'b0;
    endtask

    task automatic test_idle_write();
        cyc();
        wr_req = 1'b1; wr_x = 7'd5; wr_y = 4'd2; wr_data = 8'hA5;
        #1;
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL idle_wr_ack got=%0b want=1", wr_ack); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL idle_wr_we got=%0b want=1", mem_we); end
        checks++; if (mem_addr !== 11'd163) begin failures++; $display("FAIL idle_wr_addr got=%0d want=163", mem_addr); end
        checks++; if (mem_wdata !== 8'hA5) begin failures++; $display("FAIL idle_wr_wdata got=%0h want=a5", mem_wdata); end
        exp_mem[163] = 8'hA5;
        cyc();
        wr_req = 1'b0;
        #1;
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL idle_noreq_ack got=%0b want=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL idle_noreq_we got=%0b want=0", mem_we); end
    endtask

    task automatic test_frame();
        int pix = 0;
        int dones = 0;
        int n = 0;
        int addr_bad = 0;
        int data_bad = 0;
        int busy_bad = 0;
        int last_done_bad = 0;
        bit ended = 1'b0;
        logic [10:0] h1;
        logic [10:0] h2;
        cyc();
        frame_start = 1'b1; scan_ready = 1'b1;
        #1;
        h1 = mem_addr; h2 = mem_addr;
        // frame_start stays high through the frame, including frame_done
        while (!ended && n < NPIX * 3 + 20) begin
            cyc(); #1;
            n++;
            if (scan_busy !== 1'b1) busy_bad++;
            if (frame_done === 1'b1) dones++;
            if (scan_valid === 1'b1 && scan_ready === 1'b1) begin
                if (int'(h2) != pix) addr_bad++;
                if (scan_data !== exp_mem[pix]) data_bad++;
                if (pix == NPIX - 1) begin
                    if (frame_done !== 1'b1) last_done_bad++;
                    ended = 1'b1;
                end
                pix++;
            end
            h2 = h1;
            h1 = mem_addr;
        end
        checks++; if (pix !== NPIX) begin failures++; $display("FAIL frame_pixels got=%0d want=%0d", pix, NPIX); end
        checks++; if (addr_bad !== 0) begin failures++; $display("FAIL frame_addr_order bad=%0d want=0", addr_bad); end
        checks++; if (data_bad !== 0) begin failures++; $display("FAIL frame_data bad=%0d want=0", data_bad); end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL frame_busy bad=%0d want=0", busy_bad); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL frame_done_count got=%0d want=1", dones); end
        checks++; if (last_done_bad !== 0) begin failures++; $display("FAIL frame_done_last got=%0d want=0", last_done_bad); end
        cyc();
        frame_start = 1'b0;
        #1;
        checks++; if (scan_busy !== 1'b0) begin failures++; $display("FAIL frame_busy_after got=%0b want=0", scan_busy); end
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL frame_valid_after got=%0b want=0", scan_valid); end
        cyc(); #1;
        checks++; if (scan_busy !== 1'b0) begin failures++; $display("FAIL frame_idle_stays got=%0b want=0", scan_busy); end
    endtask

    task automatic test_conflict();
        do_reset();
        cyc();
        frame_start = 1'b1; scan_ready = 1'b1;
        #1;
        // ISSUE: first conflict, writer wins
        cyc();
        frame_start = 1'b0; wr_req = 1'b1; wr_x = 7'd1; wr_y = 4'd1; wr_data = 8'h11;
        #1;
        checks++; if (scan_busy !== 1'b1) begin failures++; $display("FAIL cf_busy got=%0b want=1", scan_busy); end
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL cf1_ack got=%0b want=1", wr_ack); end
        checks++; if (mem_addr !== 11'd80) begin failures++; $display("FAIL cf1_addr got=%0d want=80", mem_addr); end
        exp_mem[80] = 8'h11;
        // still ISSUE: second conflict, scanner wins
        cyc();
        wr_x = 7'd2; wr_data = 8'h22;
        #1;
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL cf2_ack got=%0b want=0", wr_ack); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL cf2_we got=%0b want=0", mem_we); end
        checks++; if (mem_addr !== 11'd0) begin failures++; $display("FAIL cf2_addr got=%0d want=0", mem_addr); end
        // WAIT: writer alone, granted without stalling the scanner
        cyc(); #1;
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL cf_wait_ack got=%0b want=1", wr_ack); end
        checks++; if (mem_addr !== 11'd81) begin failures++; $display("FAIL cf_wait_addr got=%0d want=81", mem_addr); end
        exp_mem[81] = 8'h22;
        cyc();
        wr_req = 1'b0;
        #1;
        checks++; if (scan_valid !== 1'b1) begin failures++; $display("FAIL cf_hold_valid got=%0b want=1", scan_valid); end
        checks++; if (scan_data !== exp_mem[0]) begin failures++; $display("FAIL cf_hold_data got=%0h want=%0h", scan_data, exp_mem[0]); end
        // ISSUE again: writer was granted last, scanner wins
        cyc();
        wr_req = 1'b1; wr_x = 7'd3; wr_y = 4'd1; wr_data = 8'h33;
        #1;
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL cf3_ack got=%0b want=0", wr_ack); end
        checks++; if (mem_addr !== 11'd1) begin failures++; $display("FAIL cf3_addr got=%0d want=1", mem_addr); end
        cyc(); #1;
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL cf4_ack got=%0b want=1", wr_ack); end
        checks++; if (mem_addr !== 11'd82) begin failures++; $display("FAIL cf4_addr got=%0d want=82", mem_addr); end
        exp_mem[82] = 8'h33;
        cyc();
        wr_req = 1'b0;
        do_reset();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        cyc();
        frame_start = 1'b1; scan_ready = 1'b0;
        #1;
        cyc(); frame_start = 1'b0; #1;
        cyc(); #1;
        cyc(); #1;
        checks++; if (scan_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b want=1", scan_valid); end
        checks++; if (scan_data !== exp_mem[0]) begin failures++; $display("FAIL bp_data got=%0h want=%0h", scan_data, exp_mem[0]); end
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            if (scan_valid !== 1'b1 || scan_data !== exp_mem[0] || mem_we !== 1'b0 || scan_busy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stall bad=%0d want=0", bad); end
        cyc();
        scan_ready = 1'b1;
        #1;
        checks++; if (scan_valid !== 1'b1) begin failures++; $display("FAIL bp_accept_valid got=%0b want=1", scan_valid); end
        cyc(); #1;
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL bp_issue_valid got=%0b want=0", scan_valid); end
        checks++; if (mem_addr !== 11'd1) begin failures++; $display("FAIL bp_next_addr got=%0d want=1", mem_addr); end
        cyc(); #1;
        cyc(); #1;
        checks++; if (scan_data !== exp_mem[1]) begin failures++; $display("FAIL bp_next_data got=%0h want=%0h", scan_data, exp_mem[1]); end
        do_reset();
    endtask

    task automatic test_range();
        do_reset();
        cyc();
        wr_req = 1'b1; wr_x = 7'd79; wr_y = 4'd0; wr_data = 8'h7E;
        #1;
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL rng_ack got=%0b want=1", wr_ack); end
`ifdef FB_ARB_RANGE_CHK_EN
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rng_we got=%0b want=0", mem_we); end
        cyc();
        wr_x = 7'd3; wr_y = 4'd0; wr_data = 8'h44;
        #1;
        checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL rng_err got=%0b want=1", wr_err); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rng_valid_we got=%0b want=1", mem_we); end
        exp_mem[3] = 8'h44;
        cyc();
        wr_req = 1'b0;
        #1;
        cyc(); #1;
        checks++; if (wr_err !== 1'b1) begin failures++; $display("FAIL rng_err_sticky got=%0b want=1", wr_err); end
`else
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rng_we got=%0b want=1", mem_we); end
        checks++; if (mem_addr !== 11'd79) begin failures++; $display("FAIL rng_addr got=%0d want=79", mem_addr); end
        exp_mem[79] = 8'h7E;
        cyc();
        wr_req = 1'b0;
        #1;
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL rng_err got=%0b want=0", wr_err); end
`endif
    endtask

    task automatic test_reset_mid();
        int pix = 0;
        int n = 0;
        do_reset();
        cyc();
        frame_start = 1'b1; scan_ready = 1'b1;
        #1;
        while (pix < 500 && n < 2000) begin
            cyc();
            frame_start = 1'b0;
            #1;
            n++;
            if (scan_valid === 1'b1 && scan_ready === 1'b1) pix++;
        end
        checks++; if (pix !== 500) begin failures++; $display("FAIL rm_pixels got=%0d want=500", pix); end
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (scan_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b want=0", scan_busy); end
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b want=0", scan_valid); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rm_done got=%0b want=0", frame_done); end
        checks++; if (scan_data !== 8'h00) begin failures++; $display("FAIL rm_data got=%0h want=0", scan_data); end
        checks++; if (mem_addr !== 11'd0) begin failures++; $display("FAIL rm_addr got=%0d want=0", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rm_we got=%0b want=0", mem_we); end
        checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL rm_err got=%0b want=0", wr_err); end
        cyc();
        rst = 1'b0;
        cyc();
        frame_start = 1'b1;
        #1;
        cyc();
        frame_start = 1'b0;
        #1;
        checks++; if (scan_busy !== 1'b1) begin failures++; $display("FAIL rm_restart_busy got=%0b want=1", scan_busy); end
        checks++; if (mem_addr !== 11'd0) begin failures++; $display("FAIL rm_restart_addr got=%0d want=0", mem_addr); end
        cyc(); #1;
        cyc(); #1;
        checks++; if (scan_data !== exp_mem[0]) begin failures++; $display("FAIL rm_restart_data got=%0h want=%0h", scan_data, exp_mem[0]); end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; scan_ready = 1'b0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        for (int i = 0; i < 2048; i++) exp_mem[i] = pat(i);
        test_reset();
        test_idle_write();
        test_frame();
        test_conflict();
        test_backpressure();
        test_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
